circuit1_bist_ctrl: RTL and testbench

Built-in self-test controller for the 3-input/1-output `circuit1` under test. It sits between mission logic and the CUT inputs and sequences a self-test. On request it takes over `x1..x3`, applies an exhaustive 3-bit pattern sequence and compacts `z` into a serial signature register. It then compares the signature against a parameterised golden value and reports pass/fail. In mission mode it passes the functional inputs straight through.

---
 rtl/circuit1_bist_ctrl_pkg.sv | 18 +
 rtl/circuit1_bist_ctrl_sig_reg.sv | 41 ++++
 rtl/circuit1_bist_ctrl.sv | 128 ++++++++++++
 tb/tb_circuit1_bist_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/circuit1_bist_ctrl_pkg.sv
// Shared definitions for the circuit1 BIST blocks: controller state encoding
// and the default signature register geometry.
package circuit1_bist_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } bist_state_e;

    localparam int         BIST_SIG_W = 8;
    // x^8 + x^4 + x^3 + x^2 + 1
    localparam logic [7:0] BIST_POLY  = 8'h1D;
    localparam int         BIST_CNT_W = 4;

endpackage

// File: rtl/circuit1_bist_ctrl_sig_reg.sv
// Serial-input signature register: shifts left, folds POLY back in when the
// MSB falls out, and XORs the serial response into bit 0.
module circuit1_bist_ctrl_sig_reg
    import circuit1_bist_ctrl_pkg::*;
#(
    parameter int               SIG_W = BIST_SIG_W,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(BIST_POLY)
) (
    input  logic             CP,
    input  logic             RN,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ {{(SIG_W-1){1'b0}}, din};
        end
    end

    always_ff @(posedge CP or negedge RN) begin
        if (!RN) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/circuit1_bist_ctrl.sv
// BIST controller for circuit1: owns x1..x3 during a test, applies an exhaustive
// 3-bit pattern sweep, compacts z into a signature and reports pass/fail.
module circuit1_bist_ctrl
    import circuit1_bist_ctrl_pkg::*;
#(
    parameter int               NPAT    = 8,
    parameter int               CUT_LAT = 1,
    parameter int               SIG_W   = BIST_SIG_W,
    parameter logic [SIG_W-1:0] POLY    = SIG_W'(BIST_POLY),
    parameter logic [SIG_W-1:0] GOLDEN  = SIG_W'(8'hFF)
) (
    input  logic             CP,
    input  logic             RN,
    input  logic             start,
    input  logic             fx1,
    input  logic             fx2,
    input  logic             fx3,
    output logic             x1,
    output logic             x2,
    output logic             x3,
    input  logic             z,
    output logic             test_mode,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [2:0]       dbg_state
);

    localparam logic [BIST_CNT_W-1:0] PC_LAST = BIST_CNT_W'(NPAT - 1);
    localparam logic [BIST_CNT_W-1:0] RC_LAST = BIST_CNT_W'(NPAT + CUT_LAT - 1);
    localparam logic [BIST_CNT_W-1:0] RC_EN   = BIST_CNT_W'(CUT_LAT);

    bist_state_e           state_q, state_d;
    logic [BIST_CNT_W-1:0] pc_q, pc_d;
    logic [BIST_CNT_W-1:0] rc_q, rc_d;
    logic                  test_mode_q, test_mode_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  sig_clr;
    logic                  sig_en;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_INIT;
            ST_INIT:  state_d = ST_RUN;
            ST_RUN:   if (rc_q == RC_LAST) state_d = ST_CHECK;
            ST_CHECK: state_d = ST_DONE;
            ST_DONE:  if (!start) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Counters are cleared on the way into INIT so the mux already shows
    // pattern 000 during the INIT cycle.
    always_comb begin
        pc_d = pc_q;
        rc_d = rc_q;
        if (state_d == ST_INIT) begin
            pc_d = '0;
            rc_d = '0;
        end else if (state_q == ST_RUN) begin
            rc_d = rc_q + 1'b1;
            if (pc_q < PC_LAST) pc_d = pc_q + 1'b1;
        end
    end

    always_comb begin
        test_mode_d = (state_d != ST_IDLE);
        busy_d      = (state_d == ST_INIT) || (state_d == ST_RUN) || (state_d == ST_CHECK);
        done_d      = (state_d == ST_DONE);
        pass_d      = pass_q;
        if (state_q == ST_CHECK) begin
            pass_d = (signature == GOLDEN);
        end else if (state_d == ST_IDLE) begin
            pass_d = 1'b0;
        end
    end

    // z lags the applied pattern by CUT_LAT cycles, so compaction starts late
    // and the RUN phase is stretched by the same amount.
    assign sig_clr = (state_q == ST_INIT);
    assign sig_en  = (state_q == ST_RUN) && (rc_q >= RC_EN);

    always_ff @(posedge CP or negedge RN) begin
        if (!RN) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            rc_q        <= '0;
            test_mode_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            rc_q        <= rc_d;
            test_mode_q <= test_mode_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    circuit1_bist_ctrl_sig_reg #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_sig_reg (
        .CP    (CP),
        .RN    (RN),
        .clr   (sig_clr),
        .en    (sig_en),
        .din   (z),
        .sig   (signature)
    );

    // Only combinational path: mission inputs reconnect as soon as test_mode drops.
    assign {x1, x2, x3} = test_mode_q ? pc_q[2:0] : {fx1, fx2, fx3};

    assign test_mode = test_mode_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_circuit1_bist_ctrl.sv
// Self-checking bench for circuit1_bist_ctrl: directed runs with hand-computed
// pattern/signature tables, scoreboard queues popped by a negedge monitor.
module tb_circuit1_bist_ctrl;
    import circuit1_bist_ctrl_pkg::*;

    logic       CP;
    logic       RN;
    logic       start;
    logic       fx1, fx2, fx3;
    logic       x1, x2, x3;
    logic       z;
    logic       test_mode;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] signature;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // {check_sig, x[2:0], sig[7:0]} per busy cycle; {pass, sig} per done rise
    logic [11:0] exp_q[$];
    logic [8:0]  res_q[$];
    logic        done_prev = 1'b0;

    // Busy cycles INIT, RUN0..RUN8, CHECK for NPAT=8, CUT_LAT=1
    logic [2:0] x_tab  [11] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7};
    logic [7:0] s1_tab [11] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

    circuit1_bist_ctrl dut (
        .CP        (CP),
        .RN        (RN),
        .start     (start),
        .fx1       (fx1),
        .fx2       (fx2),
        .fx3       (fx3),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .z         (z),
        .test_mode (test_mode),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        CP = 1'b0;
        forever #5 CP = ~CP;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic set_fx(input logic [2:0] v);
        {fx1, fx2, fx3} = v;
    endtask

    task automatic push_run(input logic zv, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i != 0), x_tab[i], (zv ? s1_tab[i] : 8'h00)});
        end
    endtask

    // Raises start, counts edges after the sampling edge until done is seen.
    // Sampling edge k opens INIT as cycle k+1, so DONE (cycle k+12) is first
    // visible 11 edges later. Optionally wiggles start mid-RUN.
    task automatic launch(input logic toggle, output int lat);
        start = 1'b1;
        @(posedge CP);
        lat = 0;
        while (lat < 40) begin
            @(posedge CP);
            lat++;
            #1;
            if (done) break;
            if (toggle && lat == 3) start = 1'b0;
            if (toggle && lat == 5) start = 1'b1;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge CP) begin
        logic [11:0] e;
        logic [8:0]  r;
        if (RN && busy) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL pattern_unexpected: busy cycle with x=%0d and nothing expected", {x1, x2, x3});
            end else begin
                e = exp_q.pop_front();
                check("pattern_x", {29'd0, x1, x2, x3}, {29'd0, e[10:8]});
                if (e[11]) check("pattern_sig", {24'd0, signature}, {24'd0, e[7:0]});
            end
        end
        if (RN && done && !done_prev) begin
            if (res_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL result_unexpected: done rose with sig=%0h and nothing expected", signature);
            end else begin
                r = res_q.pop_front();
                check("result_pass", {31'd0, pass}, {31'd0, r[8]});
                check("result_sig", {24'd0, signature}, {24'd0, r[7:0]});
            end
        end
        done_prev = done;
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        RN    = 1'b0;
        start = 1'b0;
        z     = 1'b0;
        set_fx(3'b101);
        #12;
        check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        check("rst_test_mode", {31'd0, test_mode}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd0);
        check("rst_sig", {24'd0, signature}, 32'd0);
        check("rst_x", {29'd0, x1, x2, x3}, 32'd5);
        @(posedge CP);
        #1 RN = 1'b1;
        tick();

        // mission passthrough
        check("idle_x_101", {29'd0, x1, x2, x3}, 32'd5);
        check("idle_test_mode", {31'd0, test_mode}, 32'd0);
        set_fx(3'b010);
        #1 check("idle_x_010", {29'd0, x1, x2, x3}, 32'd2);
        tick();

        // run 1: z tied 1, signature walks up to FF -> pass
        z = 1'b1;
        push_run(1'b1, 11);
        res_q.push_back({1'b1, 8'hFF});
        launch(1'b0, lat);
        check("latency_z1", lat, 32'd11);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("done_hold", {31'd0, done}, 32'd1);
            check("done_busy", {31'd0, busy}, 32'd0);
            check("done_x_last", {29'd0, x1, x2, x3}, 32'd7);
        end
        start = 1'b0;
        tick();
        check("back_idle_done", {31'd0, done}, 32'd0);
        check("back_idle_pass", {31'd0, pass}, 32'd0);
        check("back_idle_tm", {31'd0, test_mode}, 32'd0);
        check("back_idle_x", {29'd0, x1, x2, x3}, 32'd2);
        check("sig_held_idle", {24'd0, signature}, 32'hFF);
        tick();

        // run 2: z tied 0 with start wiggled mid-RUN -> sig 00, fail, same timing
        z = 1'b0;
        push_run(1'b0, 11);
        res_q.push_back({1'b0, 8'h00});
        launch(1'b1, lat);
        check("latency_z0_toggle", lat, 32'd11);
        check("fail_pass", {31'd0, pass}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("no_rerun_done", {31'd0, done}, 32'd1);
            check("no_rerun_state", {29'd0, dbg_state}, {29'd0, ST_DONE});
        end
        start = 1'b0;
        tick();
        check("z0_idle_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        check("z0_idle_pass", {31'd0, pass}, 32'd0);
        tick();

        // run 3: reset pulled during the 4th RUN cycle
        z = 1'b1;
        set_fx(3'b110);
        push_run(1'b1, 4);
        start = 1'b1;
        @(posedge CP);
        repeat (4) @(posedge CP);
        #2 RN = 1'b0;
        #1;
        check("abort_test_mode", {31'd0, test_mode}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_x", {29'd0, x1, x2, x3}, 32'd6);
        check("abort_sig", {24'd0, signature}, 32'd0);
        check("abort_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        start = 1'b0;
        tick();
        RN = 1'b1;
        repeat (3) tick();
        check("post_abort_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        check("post_abort_busy", {31'd0, busy}, 32'd0);
        set_fx(3'b011);
        #1 check("post_abort_x", {29'd0, x1, x2, x3}, 32'd3);
        tick();
        tick();

        check("exp_q_drained", exp_q.size(), 32'd0);
        check("res_q_drained", res_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
